// File: rtl/udc_buf_pkg.sv
// Shared widths, FSM state type and saturation helper for the phase capacitor
// voltage capture buffer.
package udc_buf_pkg;

  localparam int IDX_W  = 10;
  localparam int ACC_W  = 26;
  localparam int CNT_W  = 11;
  localparam int DATA_W = 16;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_PEND    = 1'b1
  } state_e;

  // Clamp an already-shifted frame sum into the 16-bit output range.
  function automatic logic [DATA_W-1:0] sat16(input logic [ACC_W-1:0] v);
    if (v > 26'h000FFFF) begin
      return 16'hFFFF;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/udc_bank_ram.sv
// Simple dual-port 2048x16 RAM: one write port, one registered read port.
// The array is not reset; only the read register clears so rd_data starts at 0.
module udc_bank_ram
  import udc_buf_pkg::*;
(
  input  logic              clk_100M,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [IDX_W:0]    waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W:0]    raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << (IDX_W + 1)) - 1];

  // Write port.
  always_ff @(posedge clk_100M) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port with synchronous clear of the output register.
  always_ff @(posedge clk_100M) begin
    if (!reset_n) begin
      rdata_o <= 16'h0000;
    end else begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/phase_udc_buf.sv
// Double-buffered capture of one phase's submodule voltages with frame sum;
// the last completed frame is served to the DPRAM writer's read port.
module phase_udc_buf
  import udc_buf_pkg::*;
#(
  parameter int N_SM      = 240,
  parameter int SUM_SHIFT = 4
) (
  input  logic              clk_100M,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  input  logic              frame_end,
  input  logic              rd_lock,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] phase_udc,
  output logic [15:0]       frame_cnt,
  output logic              frame_short,
  output logic              idx_err,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] N_SM_W = CNT_W'(N_SM);

  state_e            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              swap_q, swap_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_hold_q, acc_hold_d;
  logic [CNT_W-1:0]  sm_cnt_q, sm_cnt_d;
  logic [DATA_W-1:0] phase_q, phase_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              short_q, short_d;
  logic              idx_err_q, idx_err_d;
  logic              overrun_q, overrun_d;

  logic              accept_s;
  logic [ACC_W-1:0]  acc_new_s;
  logic [CNT_W-1:0]  cnt_new_s;
  logic              fire_s;
  logic [ACC_W-1:0]  fire_sum_s;
  logic              bank_s;

  // Next-state logic: sample accumulation, frame close, swap scheduling.
  always_comb begin
    accept_s   = in_valid && ({1'b0, in_idx} < N_SM_W);
    acc_new_s  = acc_q + (accept_s ? ACC_W'(in_data) : 26'd0);
    cnt_new_s  = sm_cnt_q + CNT_W'(accept_s);

    state_d    = state_q;
    swap_d     = 1'b0;
    acc_d      = acc_new_s;
    sm_cnt_d   = cnt_new_s;
    acc_hold_d = acc_hold_q;
    short_d    = short_q;
    idx_err_d  = idx_err_q | (in_valid & ~accept_s);
    overrun_d  = overrun_q;
    fire_s     = 1'b0;
    fire_sum_s = acc_hold_q;

    if (frame_end) begin
      acc_hold_d = acc_new_s;
      acc_d      = 26'd0;
      sm_cnt_d   = 11'd0;
      if (cnt_new_s != N_SM_W) begin
        short_d = 1'b1;
      end else begin
        short_d = short_q;
      end
    end else begin
      acc_hold_d = acc_hold_q;
    end

    case (state_q)
      S_COLLECT: begin
        // The request from the previous cycle's frame_end fires now.
        if (swap_q) begin
          fire_s     = 1'b1;
          fire_sum_s = acc_hold_q;
        end else begin
          fire_s     = 1'b0;
        end
        if (frame_end) begin
          if (rd_lock) begin
            state_d = S_PEND;
          end else begin
            swap_d  = 1'b1;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_PEND: begin
        if (frame_end) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        // Release fires immediately, using the newest sum if a frame closes too.
        if (!rd_lock) begin
          fire_s     = 1'b1;
          fire_sum_s = acc_hold_d;
          state_d    = S_COLLECT;
        end else begin
          state_d    = S_PEND;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase

    // Both RAM ports follow the post-swap bank so the swap cycle is coherent.
    bank_s      = wr_bank_q ^ fire_s;
    wr_bank_d   = bank_s;
    if (fire_s) begin
      phase_d     = sat16(fire_sum_s >> SUM_SHIFT);
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      phase_d     = phase_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_100M) begin
    if (!reset_n) begin
      state_q     <= S_COLLECT;
      wr_bank_q   <= 1'b0;
      swap_q      <= 1'b0;
      acc_q       <= 26'd0;
      acc_hold_q  <= 26'd0;
      sm_cnt_q    <= 11'd0;
      phase_q     <= 16'h0000;
      frame_cnt_q <= 16'h0000;
      short_q     <= 1'b0;
      idx_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      swap_q      <= swap_d;
      acc_q       <= acc_d;
      acc_hold_q  <= acc_hold_d;
      sm_cnt_q    <= sm_cnt_d;
      phase_q     <= phase_d;
      frame_cnt_q <= frame_cnt_d;
      short_q     <= short_d;
      idx_err_q   <= idx_err_d;
      overrun_q   <= overrun_d;
    end
  end

  udc_bank_ram u_ram (
    .clk_100M (clk_100M),
    .reset_n  (reset_n),
    .we_i     (accept_s),
    .waddr_i  ({bank_s, in_idx}),
    .wdata_i  (in_data),
    .raddr_i  ({~bank_s, rd_addr}),
    .rdata_o  (rd_data)
  );

  assign phase_udc   = phase_q;
  assign frame_cnt   = frame_cnt_q;
  assign frame_short = short_q;
  assign idx_err     = idx_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_phase_udc_buf.sv
// Self-checking bench: frame table plus hand-written lock/overrun/short/reset
// sequences on an N_SM=4 instance, and saturation on an N_SM=1024 instance.
module tb_phase_udc_buf;

  logic        clk_100M = 1'b0;
  logic        reset_n;

  logic        in_valid_a, frame_end_a, rd_lock_a;
  logic [9:0]  in_idx_a, rd_addr_a;
  logic [15:0] in_data_a, rd_data_a, phase_a, fcnt_a;
  logic        short_a, idx_err_a, overrun_a;

  logic        in_valid_b, frame_end_b, rd_lock_b;
  logic [9:0]  in_idx_b, rd_addr_b;
  logic [15:0] in_data_b, rd_data_b, phase_b, fcnt_b;
  logic        short_b, idx_err_b, overrun_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  bit          rd_pend = 1'b0;

  typedef struct packed {
    logic [3:0][15:0] d;
    logic [15:0]      exp_phase;
  } vec_t;

  vec_t vecs [5];

  always #5 clk_100M = ~clk_100M;

  phase_udc_buf #(.N_SM(4), .SUM_SHIFT(0)) dut_a (
    .clk_100M(clk_100M), .reset_n(reset_n),
    .in_valid(in_valid_a), .in_idx(in_idx_a), .in_data(in_data_a),
    .frame_end(frame_end_a), .rd_lock(rd_lock_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .phase_udc(phase_a), .frame_cnt(fcnt_a),
    .frame_short(short_a), .idx_err(idx_err_a), .overrun(overrun_a)
  );

  phase_udc_buf #(.N_SM(1024), .SUM_SHIFT(0)) dut_b (
    .clk_100M(clk_100M), .reset_n(reset_n),
    .in_valid(in_valid_b), .in_idx(in_idx_b), .in_data(in_data_b),
    .frame_end(frame_end_b), .rd_lock(rd_lock_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .phase_udc(phase_b), .frame_cnt(fcnt_b),
    .frame_short(short_b), .idx_err(idx_err_b), .overrun(overrun_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; a read issued in the previous cycle is scored here.
  task automatic step();
    bit had;
    logic [15:0] e;
    had = rd_pend;
    @(posedge clk_100M);
    #1;
    rd_pend = 1'b0;
    if (had) begin
      e = exp_q.pop_front();
      check("rd_data", {16'h0, rd_data_a}, {16'h0, e});
    end
  endtask

  task automatic rd_req(input logic [9:0] a, input logic [15:0] e);
    rd_addr_a = a;
    exp_q.push_back(e);
    rd_pend = 1'b1;
  endtask

  task automatic put(input logic [9:0] idx, input logic [15:0] d);
    in_valid_a = 1'b1;
    in_idx_a   = idx;
    in_data_a  = d;
    step();
    in_valid_a = 1'b0;
  endtask

  task automatic fend();
    frame_end_a = 1'b1;
    step();
    frame_end_a = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0][15:0] d);
    for (int i = 0; i < 4; i++) put(10'(i), d[i]);
    fend();
  endtask

  initial begin
    vecs[0] = '{d: {16'd400, 16'd300, 16'd200, 16'd100}, exp_phase: 16'd1000};
    vecs[1] = '{d: {16'd4, 16'd3, 16'd2, 16'd1}, exp_phase: 16'd10};
    vecs[2] = '{d: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp_phase: 16'hFFFF};
    vecs[3] = '{d: {16'd0, 16'd0, 16'd0, 16'd0}, exp_phase: 16'd0};
    vecs[4] = '{d: {16'd8000, 16'd7000, 16'd6000, 16'd5000}, exp_phase: 16'd26000};

    reset_n = 1'b0;
    in_valid_a = 1'b0; in_idx_a = 10'd0; in_data_a = 16'd0;
    frame_end_a = 1'b0; rd_lock_a = 1'b0; rd_addr_a = 10'd0;
    in_valid_b = 1'b0; in_idx_b = 10'd0; in_data_b = 16'd0;
    frame_end_b = 1'b0; rd_lock_b = 1'b0; rd_addr_b = 10'd0;
    repeat (3) step();
    check("rst_rd_data", {16'h0, rd_data_a}, 32'd0);
    check("rst_phase", {16'h0, phase_a}, 32'd0);
    check("rst_frame_cnt", {16'h0, fcnt_a}, 32'd0);
    check("rst_flags", {29'd0, short_a, idx_err_a, overrun_a}, 32'd0);
    check("rst_b_phase", {16'h0, phase_b}, 32'd0);
    reset_n = 1'b1;
    step();

    // Table: full frames, unlocked swaps.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].d);
      check("swap_early_cnt", {16'h0, fcnt_a}, 32'(v));
      step();
      check("tbl_phase", {16'h0, phase_a}, {16'h0, vecs[v].exp_phase});
      check("tbl_frame_cnt", {16'h0, fcnt_a}, 32'(v + 1));
      for (int i = 0; i < 4; i++) begin
        rd_req(10'(i), vecs[v].d[i]);
        step();
      end
      step();
    end
    check("tbl_flags", {29'd0, short_a, idx_err_a, overrun_a}, 32'd0);

    // Locked read: new frame of 7s stays hidden until rd_lock drops.
    rd_lock_a = 1'b1;
    send_frame({16'd7, 16'd7, 16'd7, 16'd7});
    for (int i = 0; i < 4; i++) begin
      rd_req(10'(i), vecs[4].d[i]);
      step();
    end
    check("lock_frame_cnt", {16'h0, fcnt_a}, 32'd5);
    check("lock_phase", {16'h0, phase_a}, 32'd26000);
    rd_lock_a = 1'b0;
    rd_req(10'd1, 16'd7);
    step();
    check("release_frame_cnt", {16'h0, fcnt_a}, 32'd6);
    check("release_phase", {16'h0, phase_a}, 32'd28);
    rd_req(10'd3, 16'd7);
    step();
    step();

    // Overrun: two frames while locked, one swap on release.
    rd_lock_a = 1'b1;
    send_frame({16'd1, 16'd1, 16'd1, 16'd1});
    check("ovr_not_yet", {31'd0, overrun_a}, 32'd0);
    send_frame({16'd40, 16'd30, 16'd20, 16'd10});
    check("ovr_flag", {31'd0, overrun_a}, 32'd1);
    check("ovr_locked_cnt", {16'h0, fcnt_a}, 32'd6);
    rd_lock_a = 1'b0;
    rd_req(10'd2, 16'd30);
    step();
    check("ovr_phase", {16'h0, phase_a}, 32'd100);
    check("ovr_frame_cnt", {16'h0, fcnt_a}, 32'd7);
    repeat (3) step();
    check("ovr_single_swap", {16'h0, fcnt_a}, 32'd7);

    // Short frame with an out-of-range index.
    check("pre_short", {30'd0, short_a, idx_err_a}, 32'd0);
    put(10'd0, 16'd11);
    put(10'd1, 16'd22);
    put(10'd2, 16'd33);
    put(10'd4, 16'd999);
    check("idx_err", {31'd0, idx_err_a}, 32'd1);
    fend();
    step();
    check("short_flag", {31'd0, short_a}, 32'd1);
    check("short_phase", {16'h0, phase_a}, 32'd66);
    check("short_frame_cnt", {16'h0, fcnt_a}, 32'd8);
    rd_req(10'd1, 16'd22);
    step();

    // Sample coincident with frame_end belongs to the ending frame.
    put(10'd0, 16'd1);
    put(10'd1, 16'd2);
    put(10'd2, 16'd3);
    in_valid_a = 1'b1; in_idx_a = 10'd3; in_data_a = 16'd4;
    fend();
    in_valid_a = 1'b0;
    step();
    check("samecyc_phase", {16'h0, phase_a}, 32'd10);
    check("samecyc_frame_cnt", {16'h0, fcnt_a}, 32'd9);
    rd_req(10'd3, 16'd4);
    step();

    // Reset while a swap is pending discards it.
    rd_lock_a = 1'b1;
    send_frame({16'd9, 16'd9, 16'd9, 16'd9});
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rstp_phase", {16'h0, phase_a}, 32'd0);
    check("rstp_frame_cnt", {16'h0, fcnt_a}, 32'd0);
    check("rstp_rd_data", {16'h0, rd_data_a}, 32'd0);
    check("rstp_flags", {29'd0, short_a, idx_err_a, overrun_a}, 32'd0);
    rd_lock_a = 1'b0;
    repeat (3) step();
    check("rstp_no_swap_cnt", {16'h0, fcnt_a}, 32'd0);
    check("rstp_no_swap_phase", {16'h0, phase_a}, 32'd0);

    // Saturation on the 1024-submodule instance.
    for (int i = 0; i < 1024; i++) begin
      in_valid_b = 1'b1;
      in_idx_b   = 10'(i);
      in_data_b  = 16'hFFFF;
      frame_end_b = (i == 1023);
      step();
    end
    in_valid_b = 1'b0;
    frame_end_b = 1'b0;
    step();
    check("sat_phase", {16'h0, phase_b}, 32'h0000FFFF);
    check("sat_frame_cnt", {16'h0, fcnt_b}, 32'd1);
    check("sat_flags", {29'd0, short_b, idx_err_b, overrun_b}, 32'd0);
    rd_addr_b = 10'd1023;
    step();
    check("sat_rd_data", {16'h0, rd_data_b}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_udc_buf.md
# phase_udc_buf

Double-buffered capture store for one phase's submodule capacitor voltages. It sits directly upstream of the DSP dual-port RAM writer: it collects one frame of per-submodule voltages from the valve link decoder and computes the phase voltage sum. It then serves the last completed frame to the writer's `ram_addr_x` / `ram_data_x` read port, so the DSP interrupt burst always sees a coherent frame. One instance is used per phase (A/B/C).

## Interface
Parameters:
- `N_SM`, default 240: submodules per phase, range 1..1024.
- `SUM_SHIFT`, default 4: right shift applied to the frame sum before output.

Ports (reset `reset_n`, synchronous, active-low; clock `clk_100M`):
- `clk_100M`  in  1: system clock, 100 MHz.
- `reset_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: sample strobe from the link decoder.
- `in_idx`  in  10: submodule index of the sample.
- `in_data`  in  16: capacitor voltage, unsigned.
- `frame_end`  in  1: one-cycle pulse marking the last sample of a frame.
- `rd_lock`  in  1: high while the downstream writer is copying a frame (start_DPRAM window).
- `rd_addr`  in  10: read index (`ram_addr_x`).
- `rd_data`  out  16: read data (`ram_data_x`), 1-cycle latency.
- `phase_udc`  out  16: saturated `(sum >> SUM_SHIFT)` of the frame currently being served.
- `frame_cnt`  out  16: count of bank swaps; wraps at 16 bits.
- `frame_short`  out  1: sticky; set when a frame ends with fewer than `N_SM` accepted samples.
- `idx_err`  out  1: sticky; set when `in_idx >= N_SM`.
- `overrun`  out  1: sticky; set when `frame_end` arrives while a swap is already pending.

## Operation
- **Storage:** 2 banks × 1024 × 16. Writes go to `{wr_bank, in_idx}`; reads come from `{~wr_bank, rd_addr}`.
- **Accepting samples:** a sample is accepted when `in_valid=1` and `in_idx < N_SM`. An accepted sample is written to the RAM, added to `acc` (26 bits, unsigned), and increments `sm_cnt` (11 bits).
- **Rejected samples:** if `in_idx >= N_SM`, the sample is dropped and `idx_err` is set. Rejected samples are not counted.
- **Frame end:**
  - `acc_hold <= acc + accepted sample in that cycle`; `acc` is cleared.
  - If `sm_cnt` (including a same-cycle sample) `!= N_SM`, set `frame_short`. The frame is swapped anyway.
  - `sm_cnt` is cleared.
- **State machine:**
  - `S_COLLECT`: on `frame_end` with `rd_lock=0`, swap the banks in the next cycle and stay in `S_COLLECT`. On `frame_end` with `rd_lock=1`, go to `S_PEND`.
  - `S_PEND`: collection continues into the same write bank, so the newer frame overwrites it. On `rd_lock` falling, swap and return to `S_COLLECT`. A further `frame_end` in `S_PEND` sets `overrun`, refreshes `acc_hold`, and stays in `S_PEND`.
- **Swap action:**
  - Toggle `wr_bank`.
  - `phase_udc <= min(acc_hold >> SUM_SHIFT, 16'hFFFF)`.
  - `frame_cnt <= frame_cnt + 1`.
- **Read-bank stability:** the read bank never changes while `rd_lock=1`.

## Timing
- **Reset values:** `rd_data=0`, `phase_udc=0`, `frame_cnt=0`, all flags 0, `wr_bank=0`, state `S_COLLECT`, `acc=0`, `sm_cnt=0`. RAM contents are not cleared.
- **Read:** `rd_data` is valid in cycle N+1 for `rd_addr` presented in cycle N.
- **Write-to-read:** a sample written in cycle N is readable after the swap, which occurs no earlier than `frame_end` cycle + 1.
- **Unlocked swap:** with `frame_end` in cycle N and `rd_lock=0`, the swap registers at the end of cycle N+1. `phase_udc` and `frame_cnt` update in cycle N+1, and `rd_data` reflects the new bank for addresses presented from N+1.
- **Pending swap:** if `rd_lock` falls in cycle M (first cycle low), the swap takes effect in cycle M+1.
- **Simultaneous events:** a sample with `in_valid` in the same cycle as `frame_end` belongs to the ending frame. A `frame_end` in the same cycle that `rd_lock` falls in `S_PEND` counts as a single swap, using the newest `acc_hold`; `overrun` is set.
- **Reset mid-operation:** reset during `S_PEND` discards the pending swap.

## Structure
- **Package `udc_buf_pkg`:**
  - `IDX_W=10`, `ACC_W=26`, `CNT_W=11`.
  - State enum `{S_COLLECT, S_PEND}`.
  - Saturation helper function.
- **Sub-module `udc_bank_ram`:** simple dual-port 2048×16 RAM, one write port and one registered read port, inferable as block RAM. All control logic stays in `phase_udc_buf`.

## Test plan
- **Nominal frame:** `N_SM=4`, `SUM_SHIFT=0`. Write idx 0..3 = 100, 200, 300, 400, then `frame_end` with `rd_lock=0`. Required: `phase_udc=1000` and `frame_cnt=1` two cycles after `frame_end`; reading addr 2 returns 300 one cycle later.
- **Locked read:** hold `rd_lock=1` and complete a second frame (all values 7). Required: reads still return frame 1 data and `frame_cnt` stays at 1. Drop `rd_lock`; required: one cycle later reads return 7 and `frame_cnt=2`.
- **Overrun:** two `frame_end`s while `rd_lock=1`. Required: `overrun=1` and a single swap on release. `phase_udc` equals the sum of the second frame.
- **Short frame and bad index:** send 3 samples plus one with `in_idx=4` (with `N_SM=4`), then `frame_end`. Required: `frame_short=1`, `idx_err=1`, the bad sample is absent from the sum, and the swap still occurs.
- **Saturation:** `N_SM=1024`, `SUM_SHIFT=0`, all samples 16'hFFFF. Required: `phase_udc=16'hFFFF`. Separately, sample idx 3 asserted together with `frame_end` must be included in the sum.
- **Reset in `S_PEND`:** assert `reset_n=0` for 1 cycle while in `S_PEND`. Required: all outputs return to 0 and no swap occurs after `rd_lock` falls.
